// File: rtl/bcd_stopwatch_lap.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_lap
//
// BCD stopwatch core. A prescaler divides clk into a count tick every DVSR
// cycles of go=1. Each tick moves an NDIG-digit BCD counter up or down by one.
// A lap register can freeze the displayed value while the live count keeps
// running.
//
// Parameters:
//   DVSR   clock cycles per count tick (>= 1)
//   NDIG   number of BCD digits (>= 1)
//
// Ports:
//   clk     system clock, rising-edge active
//   reset   asynchronous active-high reset
//   go      1 = run, 0 = pause (prescaler and digits hold)
//   clr     synchronous clear of prescaler, count and lap state
//   up      count direction, 1 = increment, 0 = decrement
//   lap     single-cycle pulse, toggles the display freeze
//   count   live BCD count, nibble i = digit i, digit 0 is the LSD
//   disp    lap register while frozen, otherwise the live count
//   frozen  1 while disp shows the lap register
//   wrap    one-cycle pulse in the cycle count holds the rolled-over value
// ---------------------------------------------------------------------------
module bcd_stopwatch_lap #(
    parameter int unsigned DVSR = 10_000_000,
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              clr,
    input  logic              up,
    input  logic              lap,
    output logic [4*NDIG-1:0] count,
    output logic [4*NDIG-1:0] disp,
    output logic              frozen,
    output logic              wrap
);

    localparam int unsigned PW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DVSR - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [4*NDIG-1:0] count_q, count_d;
    logic [4*NDIG-1:0] lap_reg_q, lap_reg_d;
    logic              frozen_q, frozen_d;
    logic              wrap_q, wrap_d;

    logic              tick;
    logic [4*NDIG-1:0] count_inc, count_dec;
    logic              inc_carry, dec_borrow;

    assign tick = go && (presc_q == PRESC_MAX);

    // Ripple BCD increment / decrement. The carry (borrow) out of the top digit
    // is set only when every digit was 9 (0), which is exactly the wrap case.
    always_comb begin
        logic [3:0] d;
        count_inc = count_q;
        count_dec = count_q;
        inc_carry = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            d = count_q[4*i +: 4];
            if (inc_carry) begin
                if (d == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = d + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (d == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = d - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        lap_reg_d = lap_reg_q;
        frozen_d  = frozen_q;
        wrap_d    = 1'b0;

        if (clr) begin
            presc_d   = '0;
            count_d   = '0;
            lap_reg_d = '0;
            frozen_d  = 1'b0;
        end else begin
            if (go) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                count_d = up ? count_inc : count_dec;
                wrap_d  = up ? inc_carry : dec_borrow;
            end
            // Capture uses the pre-edge count, even when a tick lands on the
            // same edge.
            if (lap) begin
                if (!frozen_q) begin
                    lap_reg_d = count_q;
                    frozen_d  = 1'b1;
                end else begin
                    frozen_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            count_q   <= '0;
            lap_reg_q <= '0;
            frozen_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            lap_reg_q <= lap_reg_d;
            frozen_q  <= frozen_d;
            wrap_q    <= wrap_d;
        end
    end

    // Both mux operands are registers, so disp carries no input-to-output path.
    assign disp   = frozen_q ? lap_reg_q : count_q;
    assign count  = count_q;
    assign frozen = frozen_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_lap.sv
module tb_bcd_stopwatch_lap;

    logic        clk = 1'b0;
    logic        reset, go, go_f, clr, up, lap;
    logic [11:0] count, disp, count_f, disp_f;
    logic        frozen, wrap, frozen_f, wrap_f;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_lap #(.DVSR(4), .NDIG(3)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .clr    (clr),
        .up     (up),
        .lap    (lap),
        .count  (count),
        .disp   (disp),
        .frozen (frozen),
        .wrap   (wrap)
    );

    bcd_stopwatch_lap #(.DVSR(1), .NDIG(3)) u_fast (
        .clk    (clk),
        .reset  (reset),
        .go     (go_f),
        .clr    (clr),
        .up     (up),
        .lap    (lap),
        .count  (count_f),
        .disp   (disp_f),
        .frozen (frozen_f),
        .wrap   (wrap_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [11:0] c, input logic [11:0] d,
                              input logic f, input logic w);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".disp"}, 32'(disp), 32'(d));
        check({tag, ".frozen"}, 32'(frozen), 32'(f));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; go_f = 1'b0; clr = 1'b0; up = 1'b1; lap = 1'b0;
        step(2);
        check_main("reset", 12'h000, 12'h000, 1'b0, 1'b0);
        check("reset.fast", 32'(count_f), 32'h0);

        // Up wrap on the DVSR=1 instance: one tick per edge.
        reset = 1'b0; go_f = 1'b1;
        step(999);
        check("fast.999", 32'(count_f), 32'h999);
        check("fast.999.wrap", 32'(wrap_f), 32'h0);
        step(1);
        check("fast.000", 32'(count_f), 32'h000);
        check("fast.000.wrap", 32'(wrap_f), 32'h1);
        step(1);
        check("fast.001", 32'(count_f), 32'h001);
        check("fast.001.wrap", 32'(wrap_f), 32'h0);
        go_f = 1'b0;

        // Basic count, DVSR=4.
        go = 1'b1;
        step(3);
        check_main("basic.e3", 12'h000, 12'h000, 1'b0, 1'b0);
        step(1);
        check_main("basic.e4", 12'h001, 12'h001, 1'b0, 1'b0);
        step(36);
        check_main("basic.e40", 12'h010, 12'h010, 1'b0, 1'b0);

        // Async reset between edges, mid-interval.
        step(2);
        #3 reset = 1'b1;
        #1;
        check_main("areset.now", 12'h000, 12'h000, 1'b0, 1'b0);
        step(2);
        check_main("areset.held", 12'h000, 12'h000, 1'b0, 1'b0);

        // Down count from reset.
        reset = 1'b0; up = 1'b0;
        step(3);
        check_main("down.e3", 12'h000, 12'h000, 1'b0, 1'b0);
        step(1);
        check_main("down.999", 12'h999, 12'h999, 1'b0, 1'b1);
        step(1);
        check_main("down.999b", 12'h999, 12'h999, 1'b0, 1'b0);
        step(3);
        check_main("down.998", 12'h998, 12'h998, 1'b0, 1'b0);

        // Pause mid-interval: two cycles already counted before go drops.
        step(2);
        go = 1'b0;
        step(10);
        check_main("pause.hold", 12'h998, 12'h998, 1'b0, 1'b0);
        go = 1'b1;
        step(1);
        check("pause.e1", 32'(count), 32'h998);
        step(1);
        check("pause.e2", 32'(count), 32'h997);

        // Direction change mid-interval.
        step(2);
        up = 1'b1;
        step(1);
        check("dir.e3", 32'(count), 32'h997);
        step(1);
        check("dir.e4", 32'(count), 32'h998);

        // Clear, then count up to 012.
        clr = 1'b1;
        step(1);
        check_main("clr", 12'h000, 12'h000, 1'b0, 1'b0);
        clr = 1'b0;
        step(48);
        check("lap.pre", 32'(count), 32'h012);

        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_main("lap.cap", 12'h012, 12'h012, 1'b1, 1'b0);
        step(11);
        check_main("lap.run", 12'h015, 12'h012, 1'b1, 1'b0);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_main("lap.rel", 12'h015, 12'h015, 1'b0, 1'b0);

        // Lap on a tick edge captures the pre-tick value.
        step(2);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_main("lap.tick", 12'h016, 12'h015, 1'b1, 1'b0);

        // clr with lap on a tick edge while frozen.
        step(3);
        clr = 1'b1; lap = 1'b1;
        step(1);
        clr = 1'b0; lap = 1'b0;
        check_main("clrprec", 12'h000, 12'h000, 1'b0, 1'b0);
        step(3);
        check("clrprec.e3", 32'(count), 32'h000);
        step(1);
        check("clrprec.e4", 32'(count), 32'h001);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
